// File: rtl/jtkcpu_busctl_pkg.sv
// Shared encodings for the KCPU byte-serial bus sequencer: FSM states,
// address-source selects, interrupt codes and their vector addresses.
package jtkcpu_busctl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_VEC  = 2'd2,
    ST_LDPC = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_PC  = 2'd0,
    SEL_IDX = 2'd1,
    SEL_PSH = 2'd2,
    SEL_OPC = 2'd3
  } sel_t;

  typedef enum logic [2:0] {
    INT_NONE = 3'd0,
    INT_IRQ  = 3'd1,
    INT_FIRQ = 3'd2,
    INT_NMI  = 3'd3,
    INT_RST  = 3'd4
  } intvec_t;

  localparam logic [15:0] VEC_IRQ  = 16'hFFF8;
  localparam logic [15:0] VEC_FIRQ = 16'hFFF6;
  localparam logic [15:0] VEC_NMI  = 16'hFFFC;
  localparam logic [15:0] VEC_RST  = 16'hFFFE;

  // Codes 5..7 are not interrupts and must not start a vector fetch.
  function automatic logic is_int(input logic [2:0] code);
    case (code)
      INT_IRQ, INT_FIRQ, INT_NMI, INT_RST: is_int = 1'b1;
      default:                             is_int = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] vec_addr(input logic [2:0] code);
    case (code)
      INT_IRQ:  vec_addr = VEC_IRQ;
      INT_FIRQ: vec_addr = VEC_FIRQ;
      INT_NMI:  vec_addr = VEC_NMI;
      INT_RST:  vec_addr = VEC_RST;
      default:  vec_addr = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/jtkcpu_busctl_shift.sv
// NB-byte shifter: assembles read bytes LSB-last and serialises write data
// MSB-first, left-aligning the active length so the top byte is always next.
module jtkcpu_busctl_shift
  import jtkcpu_busctl_pkg::*;
#(
  parameter int NB = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clr_rd,
  input  logic                  i_shift_rd,
  input  logic [BYTE_W-1:0]     i_din,
  input  logic                  i_load_wr,
  input  logic [BYTE_W*NB-1:0]  i_wdata,
  input  logic [2:0]            i_len,
  input  logic                  i_shift_wr,
  output logic [BYTE_W*NB-1:0]  o_rdata,
  output logic [BYTE_W-1:0]     o_dout
);

  localparam int DW = BYTE_W * NB;

  logic [DW-1:0] r_rd;
  logic [DW-1:0] r_wr;
  logic [DW-1:0] w_algn;
  logic [DW-1:0] w_nxt_rd;

  always_comb begin
    w_algn = i_wdata << (BYTE_W * (NB - int'(i_len)));
  end

  if (NB == 1) begin : g_one
    assign w_nxt_rd = i_din;
  end else begin : g_multi
    assign w_nxt_rd = {r_rd[DW-BYTE_W-1:0], i_din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
    end else if (i_en) begin
      if (i_clr_rd)        r_rd <= '0;
      else if (i_shift_rd) r_rd <= w_nxt_rd;
      if (i_load_wr)       r_wr <= w_algn;
      else if (i_shift_wr) r_wr <= r_wr << BYTE_W;
    end
  end

  assign o_rdata = r_rd;
  assign o_dout  = r_wr[DW-1 -: BYTE_W];

endmodule

// File: rtl/jtkcpu_busctl.sv
// KCPU bus sequencer: 1..NB byte big-endian transfers and interrupt vector
// fetch on the 2x bus clock enable. JTKCPU_WAITST_EN enables rdy wait states.
module jtkcpu_busctl
  import jtkcpu_busctl_pkg::*;
#(
  parameter int AW = 16,
  parameter int NB = 2,
  parameter int LW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              halt,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        sel,
  input  logic [LW-1:0]     len,
  input  logic [AW-1:0]     pc,
  input  logic [AW-1:0]     idx_addr,
  input  logic [AW-1:0]     psh_addr,
  input  logic [8*NB-1:0]   wdata,
  input  logic [2:0]        intvec,
  input  logic [7:0]        din,
  input  logic              rdy,
  output logic [AW-1:0]     addr,
  output logic [7:0]        dout,
  output logic              we,
  output logic [8*NB-1:0]   rdata,
  output logic              busy,
  output logic              done,
  output logic              is_op,
  output logic              up_pc
);

  function automatic logic [2:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0)       return 3'd1;
    if (int'(l) > NB)  return 3'(NB);
    return 3'(l);
  endfunction

  state_t        r_state;
  state_t        w_state_nx;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_cnt;
  logic          r_wr;
  logic          r_we;
  logic          r_busy;
  logic          r_done;
  logic          r_is_op;
  logic          r_up_pc;
  logic          r_vec_blk;

  logic          w_tick;
  logic          w_rdy;
  logic          w_acc_vec;
  logic          w_acc_req;
  logic          w_beat;
  logic          w_last;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_vec_addr;
  logic [2:0]    w_len;

  assign w_tick     = cen & ~halt;
  assign w_len      = clamp_len(len);
  assign w_vec_addr = AW'(vec_addr(intvec));

`ifdef JTKCPU_WAITST_EN
  assign w_rdy = rdy;
`else
  logic w_unused_rdy;
  assign w_rdy        = 1'b1;
  assign w_unused_rdy = rdy;
`endif

  always_comb begin
    case (sel)
      SEL_IDX: w_src = idx_addr;
      SEL_PSH: w_src = psh_addr;
      default: w_src = pc;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_acc_vec  = 1'b0;
    w_acc_req  = 1'b0;
    w_beat     = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (is_int(intvec) && !r_vec_blk) begin
          w_acc_vec  = 1'b1;
          w_state_nx = ST_VEC;
        end else if (req) begin
          w_acc_req  = 1'b1;
          w_state_nx = ST_XFER;
        end
      end
      ST_XFER, ST_VEC: begin
        if (w_rdy) begin
          w_beat = 1'b1;
          if (r_cnt == 3'd1) begin
            w_last     = 1'b1;
            w_state_nx = (r_state == ST_VEC) ? ST_LDPC : ST_IDLE;
          end
        end
      end
      ST_LDPC: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_is_op   <= 1'b0;
      r_up_pc   <= 1'b0;
      r_vec_blk <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      r_up_pc <= 1'b0;
      if (intvec == '0) r_vec_blk <= 1'b0;
      if (w_acc_vec) begin
        r_addr  <= w_vec_addr;
        r_cnt   <= 3'd2;
        r_wr    <= 1'b0;
        r_busy  <= 1'b1;
        r_is_op <= 1'b0;
      end else if (w_acc_req) begin
        r_addr  <= w_src;
        r_cnt   <= w_len;
        r_wr    <= wr;
        r_we    <= wr;
        r_busy  <= 1'b1;
        r_is_op <= (sel == SEL_OPC);
      end
      if (w_beat) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt - 1'b1;
        if (w_last) begin
          r_we   <= 1'b0;
          r_busy <= 1'b0;
          if (r_state == ST_VEC) r_up_pc <= 1'b1;
          else                   r_done  <= 1'b1;
        end
      end
      // A vector still asserted when the fetch completes must drop to 0 first.
      if (r_state == ST_LDPC) r_vec_blk <= (intvec != '0);
    end
  end

  jtkcpu_busctl_shift #(
    .NB (NB)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_tick),
    .i_clr_rd   (w_acc_vec),
    .i_shift_rd (w_beat & ~r_wr),
    .i_din      (din),
    .i_load_wr  (w_acc_req & wr),
    .i_wdata    (wdata),
    .i_len      (w_len),
    .i_shift_wr (w_beat & r_wr),
    .o_rdata    (rdata),
    .o_dout     (dout)
  );

  assign addr  = r_addr;
  assign we    = r_we;
  assign busy  = r_busy;
  assign done  = r_done;
  assign is_op = r_is_op;
  assign up_pc = r_up_pc;

endmodule

// File: tb/tb_jtkcpu_busctl.sv
// Scoreboard bench for jtkcpu_busctl (AW=16, NB=2, LW=2): directed transfers,
// expected beats and completions queued at issue, checked by a monitor.
module tb_jtkcpu_busctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen = 1'b0;
  logic        halt;
  logic        req;
  logic        wr;
  logic [1:0]  sel;
  logic [1:0]  len;
  logic [15:0] pc, idx_addr, psh_addr;
  logic [15:0] wdata;
  logic [2:0]  intvec;
  logic [7:0]  din;
  logic        rdy;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic [15:0] rdata;
  logic        busy, done, is_op, up_pc;

  logic [7:0]  mem [0:65535];
  int          tick = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        rdy_eff;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  dout;
    bit          chk_dout;
  } beat_t;

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] mask;
    logic        is_op;
    int          cen_no;
  } resp_t;

  beat_t beat_q[$];
  resp_t done_q[$];
  resp_t vec_q[$];

  jtkcpu_busctl #(.AW(16), .NB(2), .LW(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .halt(halt), .req(req), .wr(wr),
    .sel(sel), .len(len), .pc(pc), .idx_addr(idx_addr), .psh_addr(psh_addr),
    .wdata(wdata), .intvec(intvec), .din(din), .rdy(rdy), .addr(addr),
    .dout(dout), .we(we), .rdata(rdata), .busy(busy), .done(done),
    .is_op(is_op), .up_pc(up_pc)
  );

`ifdef JTKCPU_WAITST_EN
  assign rdy_eff = rdy;
`else
  assign rdy_eff = 1'b1;
`endif

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 cen = ~cen;
    end
  end

  always @(posedge clk) if (cen) tick <= tick + 1;

  always_comb din = mem[addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: runs just ahead of each cen edge the DUT will act on.
  always @(negedge clk) begin
    beat_t b;
    resp_t r;
    if (!rst && cen && !halt) begin
      if (busy && rdy_eff) begin
        if (beat_q.size() == 0) chk("beat_expected", 0, 1);
        else begin
          b = beat_q.pop_front();
          chk("beat_addr", {16'h0, addr}, {16'h0, b.addr});
          chk("beat_we", {31'h0, we}, {31'h0, b.we});
          if (b.chk_dout) chk("beat_dout", {24'h0, dout}, {24'h0, b.dout});
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_expected", 0, 1);
        else begin
          r = done_q.pop_front();
          chk("done_cen", tick + 1, r.cen_no);
          chk("done_rdata", {16'h0, rdata & r.mask}, {16'h0, r.rdata & r.mask});
          chk("done_is_op", {31'h0, is_op}, {31'h0, r.is_op});
          chk("done_we_low", {31'h0, we}, 32'h0);
        end
      end
      if (up_pc) begin
        if (vec_q.size() == 0) chk("up_pc_expected", 0, 1);
        else begin
          r = vec_q.pop_front();
          chk("up_pc_cen", tick + 1, r.cen_no);
          chk("vector", {16'h0, rdata}, {16'h0, r.rdata});
          chk("vec_is_op", {31'h0, is_op}, 32'h0);
        end
      end
    end
  end

  task automatic cen_edge();
    @(posedge clk iff (cen == 1'b1));
    #2;
  endtask

  task automatic push_beat(input logic [15:0] a, input logic w, input logic [7:0] d);
    beat_q.push_back('{addr: a, we: w, dout: d, chk_dout: w});
  endtask

  task automatic push_done(input logic [15:0] rd, input logic [15:0] mk, input logic op, input int cno);
    done_q.push_back('{rdata: rd, mask: mk, is_op: op, cen_no: cno});
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [1:0] l);
    wr  = w;
    sel = s;
    len = l;
    req = 1'b1;
    cen_edge();
    req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0 || vec_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_timeout"}, n < 400, 1);
    cen_edge();
    cen_edge();
  endtask

  initial begin
    int a;
    logic [15:0] exp_a [3];
    rst = 1'b1; halt = 1'b0; req = 1'b0; wr = 1'b0; sel = 2'd0; len = 2'd0;
    pc = 16'h0; idx_addr = 16'h0; psh_addr = 16'h0; wdata = 16'h0;
    intvec = 3'd0; rdy = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'h12; mem[16'h1235] = 8'h34;
    mem[16'hFFF6] = 8'h80; mem[16'hFFF7] = 8'h00;
    mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'hC3;
    mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22;
    mem[16'h0100] = 8'hA5; mem[16'h0101] = 8'h5A; mem[16'h0102] = 8'h3C;

    repeat (4) @(posedge clk);
    #2;
    chk("rst_addr", {16'h0, addr}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_we", {31'h0, we}, 32'h0);
    chk("rst_rdata", {16'h0, rdata}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_is_op", {31'h0, is_op}, 32'h0);
    chk("rst_up_pc", {31'h0, up_pc}, 32'h0);
    rst = 1'b0;
    cen_edge();

    // 2-byte read through idx_addr
    idx_addr = 16'h1234;
    a = tick + 1;
    push_beat(16'h1234, 1'b0, 8'h00);
    push_beat(16'h1235, 1'b0, 8'h00);
    push_done(16'h1234, 16'hFFFF, 1'b0, a + 3);
    issue(1'b0, 2'd1, 2'd2);
    wait_idle("read2");

    // 2-byte write through psh_addr, address wraps
    psh_addr = 16'hFFFF;
    wdata    = 16'hABCD;
    a = tick + 1;
    push_beat(16'hFFFF, 1'b1, 8'hAB);
    push_beat(16'h0000, 1'b1, 8'hCD);
    push_done(16'h0000, 16'h0000, 1'b0, a + 3);
    issue(1'b1, 2'd2, 2'd2);
    wait_idle("write2");

    // FIRQ together with a request: vector wins, request dropped
    pc     = 16'h4000;
    intvec = 3'd2;
    a = tick + 1;
    push_beat(16'hFFF6, 1'b0, 8'h00);
    push_beat(16'hFFF7, 1'b0, 8'h00);
    vec_q.push_back('{rdata: 16'h8000, mask: 16'hFFFF, is_op: 1'b0, cen_no: a + 3});
    issue(1'b0, 2'd0, 2'd1);
    wait_idle("firq");
    repeat (4) begin
      chk("vec_held_not_reserviced", {31'h0, busy}, 32'h0);
      cen_edge();
    end
    intvec = 3'd0;
    cen_edge();

    // rdy low for 3 cen right after acceptance of a 2-byte read
    pc = 16'h2000;
    a = tick + 1;
    push_beat(16'h2000, 1'b0, 8'h00);
    push_beat(16'h2001, 1'b0, 8'h00);
`ifdef JTKCPU_WAITST_EN
    push_done(16'h5AC3, 16'hFFFF, 1'b0, a + 6);
    exp_a[0] = 16'h2000; exp_a[1] = 16'h2000; exp_a[2] = 16'h2000;
`else
    push_done(16'h5AC3, 16'hFFFF, 1'b0, a + 3);
    exp_a[0] = 16'h2001; exp_a[1] = 16'h2002; exp_a[2] = 16'h2002;
`endif
    issue(1'b0, 2'd0, 2'd2);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cen_edge();
      chk("waitst_addr", {16'h0, addr}, {16'h0, exp_a[i]});
    end
    rdy = 1'b1;
    wait_idle("waitst");

    // halt for 2 cen right after acceptance
    idx_addr = 16'h3000;
    a = tick + 1;
    push_beat(16'h3000, 1'b0, 8'h00);
    push_beat(16'h3001, 1'b0, 8'h00);
    push_done(16'h1122, 16'hFFFF, 1'b0, a + 5);
    issue(1'b0, 2'd1, 2'd2);
    halt = 1'b1;
    repeat (2) begin
      cen_edge();
      chk("halt_addr", {16'h0, addr}, 32'h3000);
    end
    halt = 1'b0;
    wait_idle("halt");

    // len=3 clamps to 2 beats
    pc = 16'h0100;
    a = tick + 1;
    push_beat(16'h0100, 1'b0, 8'h00);
    push_beat(16'h0101, 1'b0, 8'h00);
    push_done(16'hA55A, 16'hFFFF, 1'b0, a + 3);
    issue(1'b0, 2'd0, 2'd3);
    wait_idle("len3");

    // len=0 is one beat; sel=3 flags an opcode fetch
    pc = 16'h0102;
    a = tick + 1;
    push_beat(16'h0102, 1'b0, 8'h00);
    push_done(16'h003C, 16'h00FF, 1'b1, a + 2);
    issue(1'b0, 2'd3, 2'd0);
    wait_idle("len0_op");

    // reset after the first byte of a write
    pc    = 16'h5000;
    wdata = 16'hBEEF;
    push_beat(16'h5000, 1'b1, 8'hBE);
    issue(1'b1, 2'd0, 2'd2);
    cen_edge();
    rst = 1'b1;
    #1;
    chk("abort_we", {31'h0, we}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_addr", {16'h0, addr}, 32'h0);
    chk("abort_dout", {24'h0, dout}, 32'h0);
    chk("abort_beats_used", beat_q.size(), 0);
    beat_q.delete();
    done_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    cen_edge();

    pc = 16'h0102;
    a = tick + 1;
    push_beat(16'h0102, 1'b0, 8'h00);
    push_done(16'h003C, 16'h00FF, 1'b0, a + 2);
    issue(1'b0, 2'd0, 2'd1);
    wait_idle("after_rst");

    chk("beat_q_drained", beat_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtkcpu_busctl.md
Name: jtkcpu_busctl

Overview:
- Parametrised successor to the KCPU memory controller: a byte-serial bus sequencer that performs 1..NB-byte big-endian reads and writes.
- Runs on the 2x bus clock enable and selects the address source (PC, indexed, stack).
- Fetches interrupt vectors and inserts wait states from a bus-ready input.
- Sits between the KCPU control unit/ALU and the external 8-bit memory bus.

Parameters:
- AW, 16, address width in bits.
- NB, 2, maximum bytes per transfer (1..4); data buses are 8*NB wide.
- LW, 2, width of the len request field; must satisfy 2^LW > NB.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cen  in  1  bus clock enable (2x CPU rate); all state advances only when cen=1
- halt  in  1  freezes all state, including outputs
- req  in  1  transfer request, sampled in IDLE
- wr  in  1  1=write, 0=read; latched with req
- sel  in  2  address source: 0=pc, 1=idx_addr, 2=psh_addr, 3=pc with is_op
- len  in  LW  bytes to transfer; 0 treated as 1, values >NB clamped to NB
- pc, idx_addr, psh_addr  in  AW  address sources
- wdata  in  8*NB  write data, right-aligned, MSB sent first
- intvec  in  3  interrupt code: 0=none, 1=IRQ, 2=FIRQ, 3=NMI, 4=RST, 5-7 ignored
- din  in  8  memory read data
- rdy  in  1  bus ready; 0 stretches the current beat
- addr  out  AW  memory address
- dout  out  8  memory write data
- we  out  1  write strobe
- rdata  out  8*NB  read data, right-aligned
- busy  out  1  high from acceptance until done
- done  out  1  one-cen pulse after the last beat
- is_op  out  1  rdata[7:0] holds an opcode (sel=3 transfer)
- up_pc  out  1  one-cen pulse: rdata[15:0] is a vector to load into PC

Behaviour:
- Reset values: addr=0, dout=0, we=0, rdata=0, busy=0, done=0, is_op=0, up_pc=0, state=IDLE.
- States: IDLE, XFER, VEC, LDPC. Transitions occur only on cen && !halt.
- IDLE:
  - If intvec is 1..4, go to VEC; this has priority over req.
  - addr=vector (IRQ FFF8, FIRQ FFF6, NMI FFFC, RST FFFE, zero-extended/truncated to AW); cnt=2; rdata cleared; busy=1.
  - Else if req: latch wr; addr=selected source; cnt=clamp(len); busy=1; is_op=(sel==3); if wr, dout=first (MSB) byte of the active length and we=1; go to XFER.
- XFER, one beat per cen with rdy=1:
  - Read: rdata <= {rdata[8*NB-9:0], din}.
  - Write: advance dout to the next byte; we stays 1 while bytes remain.
  - Each beat: addr=addr+1, wrapping modulo 2^AW; cnt=cnt-1.
  - After the final beat: we=0, busy=0, done=1 for one cen, return to IDLE.
  - rdy=0: addr, dout, we and cnt hold; the beat repeats.
- VEC: two read beats as above, then go to LDPC. is_op=0.
- LDPC: up_pc=1 for one cen; busy=0; return to IDLE. The vector is valid on rdata[15:0].
- Read latency: a 1-byte read yields done N+1 cen ticks after acceptance, with N = bytes + stalled ticks.
- req and intvec are ignored while busy; an intvec held at the end of LDPC is not re-serviced until it returns to 0.
- halt=1 stalls everything, including the done/up_pc pulses, which then persist until halt drops.
- rst mid-transfer aborts immediately to reset values; no partial we.
- Single-cycle outputs (done, up_pc) clear on the next cen tick.

Optional Feature:
- Macro JTKCPU_WAITST_EN.
- Defined: rdy is honoured as above.
- Undefined: rdy is ignored (treated as 1); the port remains but is unused, and every beat takes exactly one cen.

Decomposition:
- Package jtkcpu_busctl_pkg:
  - State encoding (IDLE/XFER/VEC/LDPC).
  - sel codes.
  - intvec codes.
  - Vector address constants VEC_IRQ/VEC_FIRQ/VEC_NMI/VEC_RST.
- One sub-module, jtkcpu_busctl_shift: NB-byte shift register doing read assembly and write serialisation with len alignment.

Test Plan:
- Read, len=2, sel=1, idx_addr=1234, din 12 then 34 -> addr 1234, 1235; rdata=1234; done 3 cen after acceptance; we=0 throughout.
- Write, len=2, wdata=ABCD, psh_addr=FFFF -> dout AB at addr FFFF, then CD at addr 0000 (wrap); we high 2 beats; done once.
- Interrupt: intvec=2 and req together, mem[FFF6]=80, mem[FFF7]=00 -> request ignored; addr FFF6, FFF7; up_pc pulse with rdata[15:0]=8000.
- Wait state (JTKCPU_WAITST_EN): rdy=0 for 3 cen on byte 1 of a 2-byte read -> addr held 3 ticks; done at tick 6; rdata correct.
- Clamp/len0, NB=2: len=3 gives 2 beats; len=0 gives 1 beat; sel=3 sets is_op=1.
- rst asserted mid-write after byte 1 -> we=0, busy=0, addr=0 immediately; next req starts cleanly.
